// File: rtl/nn_row_packer_pkg.sv
// nn_pkg: shared constants and types for the nn_row_packer slice.
//   BYTES_PER_ROW / ROW_W     : row geometry (20 bytes -> 160-bit row bus)
//   BYTE_IDX_W                : width of the byte index inside a row
//   PH_DATA / PH_WEIGHT       : phase encodings driven on the phase output
//   state_t                   : packer FSM states
//   idx_w()                   : index width helper that never returns 0
package nn_pkg;

  localparam int BYTES_PER_ROW = 20;
  localparam int ROW_W         = 8 * BYTES_PER_ROW;
  localparam int BYTE_IDX_W    = $clog2(BYTES_PER_ROW);

  localparam logic PH_DATA   = 1'b0;
  localparam logic PH_WEIGHT = 1'b1;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  // A one-entry counter still needs a 1-bit register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_row_packer_if.sv
// nn_row_packer_if: byte-stream input and row-bus output of the packer.
//   s_valid/s_data/s_last/s_ready : 8-bit valid/ready byte stream
//   row_data/count/row_valid      : row bus towards nnctrl (in1 = row_data[7:0])
//   phase/frame_done/sync_err     : frame position and framing status
// Modports: master = upstream feeder (drives the byte stream, observes the
// row bus); slave = the packer itself.
interface nn_row_packer_if;
  import nn_pkg::*;

  logic             s_valid;
  logic [7:0]       s_data;
  logic             s_last;
  logic             s_ready;
  logic [ROW_W-1:0] row_data;
  logic [7:0]       count;
  logic             row_valid;
  logic             phase;
  logic             frame_done;
  logic             sync_err;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, row_data, count, row_valid, phase, frame_done, sync_err
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, row_data, count, row_valid, phase, frame_done, sync_err
  );

endinterface

// File: rtl/nn_row_packer_shift.sv
// nn_row_shift: byte-addressed shadow row plus the visible output row.
//   clk, rst_n : clock, async active-low reset
//   wr_en      : write wr_data into shadow lane wr_idx
//   wr_idx     : byte lane being written
//   wr_data    : incoming byte
//   load       : copy the shadow to row_data, taking lane wr_idx from wr_data
//                directly so the final byte of a row lands in the same cycle
//   row_data   : visible row; only changes on load
module nn_row_shift
  import nn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [BYTE_IDX_W-1:0] wr_idx,
  input  logic [7:0]            wr_data,
  input  logic                  load,
  output logic [ROW_W-1:0]      row_data
);

  for (genvar i = 0; i < BYTES_PER_ROW; i++) begin : g_lane
    localparam logic [BYTE_IDX_W-1:0] LANE = BYTE_IDX_W'(i);

    logic       hit;
    logic [7:0] shadow_b;
    logic [7:0] row_b;

    assign hit = (wr_idx == LANE);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_b <= '0;
        row_b    <= '0;
      end else begin
        if (wr_en && hit) shadow_b <= wr_data;
        if (load)         row_b    <= hit ? wr_data : shadow_b;
      end
    end

    assign row_data[8*i +: 8] = row_b;
  end

endmodule

// File: rtl/nn_row_packer.sv
// nn_row_packer: packs a byte stream into 20-byte rows for nnctrl.
//   clock : system clock, rising edge
//   reset : asynchronous reset, active low
//   bus   : nn_row_packer_if.slave (byte stream in, row bus out)
// A frame is DATA_ROWS feature rows followed by NEURONS blocks of WEIGHT_ROWS
// weight rows. Each row is held HOLD_DATA / HOLD_WEIGHT cycles (s_ready low)
// so nnctrl can absorb it. s_last must mark the final byte of the frame; a
// stray s_last drops the partial row and restarts the frame, a missing one
// lets the frame finish. Either case sets the sticky sync_err.
module nn_row_packer
  import nn_pkg::*;
#(
  parameter int DATA_ROWS   = 50,
  parameter int WEIGHT_ROWS = 50,
  parameter int NEURONS     = 100,
  parameter int HOLD_DATA   = 10,
  parameter int HOLD_WEIGHT = 1
) (
  input  logic           clock,
  input  logic           reset,
  nn_row_packer_if.slave bus
);

  localparam int BLK_W = idx_w(NEURONS);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_ROW - 1);
  localparam logic [7:0]            DR_LAST   = 8'(DATA_ROWS - 1);
  localparam logic [7:0]            WR_LAST   = 8'(WEIGHT_ROWS - 1);
  localparam logic [BLK_W-1:0]      BLK_LAST  = BLK_W'(NEURONS - 1);
  localparam logic [7:0]            HOLD_D    = 8'(HOLD_DATA);
  localparam logic [7:0]            HOLD_W    = 8'(HOLD_WEIGHT);

  state_t                state, state_nxt;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic [7:0]            row_idx;
  logic [BLK_W-1:0]      blk_idx;
  logic [7:0]            hold_cnt;
  logic                  phase_q;
  logic [7:0]            count_q;
  logic                  row_valid_q;
  logic                  frame_done_q;
  logic                  sync_err_q;
  logic                  ready_q;

  logic accept, last_byte, final_pos, frame_err, miss_last, commit, hold_end;

  assign accept    = bus.s_valid && ready_q;
  assign last_byte = (byte_idx == LAST_BYTE);
  assign final_pos = (phase_q == PH_WEIGHT) && (row_idx == WR_LAST) && (blk_idx == BLK_LAST);
  // s_last anywhere but the final byte of the frame is a framing error.
  assign frame_err = accept && bus.s_last && !(last_byte && final_pos);
  assign miss_last = accept && last_byte && final_pos && !bus.s_last;
  assign commit    = accept && last_byte && !frame_err;
  assign hold_end  = (state == S_HOLD) && (hold_cnt == 8'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (commit)   state_nxt = S_HOLD;
      S_HOLD:  if (hold_end) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_FILL;
      byte_idx     <= '0;
      row_idx      <= '0;
      blk_idx      <= '0;
      hold_cnt     <= '0;
      phase_q      <= PH_DATA;
      count_q      <= '0;
      row_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state        <= state_nxt;
      // Registered ready tracks the next state so s_ready stays 0 in reset.
      ready_q      <= (state_nxt == S_FILL);
      row_valid_q  <= commit;
      frame_done_q <= 1'b0;

      if (frame_err || miss_last) sync_err_q <= 1'b1;

      if (accept) byte_idx <= (last_byte || frame_err) ? '0 : byte_idx + 1'b1;

      if (commit) begin
        count_q  <= row_idx;
        hold_cnt <= (phase_q == PH_WEIGHT) ? HOLD_W : HOLD_D;
      end

      if (frame_err) begin
        row_idx <= '0;
        blk_idx <= '0;
        phase_q <= PH_DATA;
      end

      if (state == S_HOLD) hold_cnt <= hold_cnt - 8'd1;

      // Indices advance only once the hold expires so count/phase describe
      // the row currently on the bus for its whole hold window.
      if (hold_end) begin
        if (phase_q == PH_DATA) begin
          if (row_idx == DR_LAST) begin
            row_idx <= '0;
            phase_q <= PH_WEIGHT;
          end else begin
            row_idx <= row_idx + 8'd1;
          end
        end else if (row_idx == WR_LAST) begin
          row_idx <= '0;
          if (blk_idx == BLK_LAST) begin
            blk_idx      <= '0;
            phase_q      <= PH_DATA;
            frame_done_q <= 1'b1;
          end else begin
            blk_idx <= blk_idx + 1'b1;
          end
        end else begin
          row_idx <= row_idx + 8'd1;
        end
      end
    end
  end

  nn_row_shift u_shift (
    .clk      (clock),
    .rst_n    (reset),
    .wr_en    (accept),
    .wr_idx   (byte_idx),
    .wr_data  (bus.s_data),
    .load     (commit),
    .row_data (bus.row_data)
  );

  assign bus.s_ready    = ready_q;
  assign bus.count      = count_q;
  assign bus.row_valid  = row_valid_q;
  assign bus.phase      = phase_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_nn_row_packer.sv
// Bench for nn_row_packer with a reduced frame geometry so whole frames fit
// in a short run. Expected rows come from the byte stream itself: row r of a
// frame is bytes 20r..20r+19, with count/phase derived from r.
module tb_nn_row_packer;
  import nn_pkg::*;

  localparam int DR = 6;
  localparam int WR = 20;
  localparam int NB = 6;
  localparam int HD = 10;
  localparam int HW = 1;
  localparam int FRAME_ROWS = DR + NB * WR;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  nn_row_packer_if bus ();

  nn_row_packer #(
    .DATA_ROWS   (DR),
    .WEIGHT_ROWS (WR),
    .NEURONS     (NB),
    .HOLD_DATA   (HD),
    .HOLD_WEIGHT (HW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [ROW_W-1:0] d;
    logic [7:0]       c;
    logic             p;
  } row_t;

  row_t             obs_q[$];
  row_t             exp_q[$];
  int               checks   = 0;
  int               failures = 0;
  int               done_cnt = 0;
  logic [ROW_W-1:0] prev_row = '0;

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row log and "row_data only moves with row_valid" check.
  always @(negedge clock) begin
    row_t r;
    if (reset) begin
      if (bus.row_valid) begin
        r.d = bus.row_data;
        r.c = bus.count;
        r.p = bus.phase;
        obs_q.push_back(r);
      end else begin
        chk("row_stable", bus.row_data, prev_row);
      end
      if (bus.frame_done) done_cnt++;
    end
    prev_row = bus.row_data;
  end

  task automatic send_byte(input logic [7:0] d, input logic l, input bit rnd);
    int guard;
    guard = 0;
    if (rnd) while ($urandom_range(1, 0) == 0) begin @(posedge clock); #1; end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!bus.s_ready && guard < 100) begin @(posedge clock); #1; guard++; end
    chk("ready_timeout", ROW_W'(guard < 100), ROW_W'(1));
    @(posedge clock); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  function automatic row_t exp_row(input logic [ROW_W-1:0] d, input int r);
    row_t e;
    e.d = d;
    e.c = (r < DR) ? 8'(r) : 8'((r - DR) % WR);
    e.p = (r >= DR);
    return e;
  endfunction

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] v;
    for (int j = 0; j < BYTES_PER_ROW; j++) v[8*j +: 8] = 8'($urandom);
    return v;
  endfunction

  task automatic send_row(input logic [ROW_W-1:0] d, input int r, input bit rnd, input bit last);
    exp_q.push_back(exp_row(d, r));
    for (int j = 0; j < BYTES_PER_ROW; j++)
      send_byte(d[8*j +: 8], last && (j == BYTES_PER_ROW - 1), rnd);
  endtask

  task automatic send_rows(input int first, input int n, input bit rnd, input bit last_at_end);
    for (int r = first; r < first + n; r++)
      send_row(rand_row(), r, rnd, last_at_end && (r == first + n - 1));
  endtask

  task automatic check_rows(input string tag);
    repeat (2) @(posedge clock);
    #1;
    chk({tag, "_rows"}, ROW_W'(obs_q.size()), ROW_W'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_data"},  obs_q[i].d, exp_q[i].d);
      chk({tag, "_count"}, ROW_W'(obs_q[i].c), ROW_W'(exp_q[i].c));
      chk({tag, "_phase"}, ROW_W'(obs_q[i].p), ROW_W'(exp_q[i].p));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = 8'h00;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    obs_q.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    logic [ROW_W-1:0] rr;
    int n;

    // 1. reset with s_valid high
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA5;
    bus.s_last  = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready",     ROW_W'(bus.s_ready),    '0);
    chk("rst_row_valid", ROW_W'(bus.row_valid),  '0);
    chk("rst_row_data",  bus.row_data,           '0);
    chk("rst_count",     ROW_W'(bus.count),      '0);
    chk("rst_phase",     ROW_W'(bus.phase),      '0);
    chk("rst_done",      ROW_W'(bus.frame_done), '0);
    chk("rst_sync_err",  ROW_W'(bus.sync_err),   '0);
    @(posedge clock); #1;
    bus.s_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rel_ready", ROW_W'(bus.s_ready), ROW_W'(1));

    // 2. bytes 0x01..0x14 back to back
    for (int j = 0; j < BYTES_PER_ROW; j++) rr[8*j +: 8] = 8'(j + 1);
    send_row(rr, 0, 1'b0, 1'b0);
    chk("s2_row_valid", ROW_W'(bus.row_valid),          ROW_W'(1));
    chk("s2_in1",       ROW_W'(bus.row_data[7:0]),      ROW_W'(8'h01));
    chk("s2_in20",      ROW_W'(bus.row_data[159:152]),  ROW_W'(8'h14));
    chk("s2_count",     ROW_W'(bus.count),              '0);
    chk("s2_phase",     ROW_W'(bus.phase),              '0);
    n = 0;
    while (!bus.s_ready && n < 50) begin n++; @(posedge clock); #1; end
    chk("s2_hold_cycles", ROW_W'(n), ROW_W'(HD));
    check_rows("s2");

    // 3. full frame back to back, s_last on the final byte
    do_reset();
    send_rows(0, DR, 1'b0, 1'b0);
    send_row(rand_row(), DR, 1'b0, 1'b0);
    chk("s3_wt_valid",    ROW_W'(bus.row_valid), ROW_W'(1));
    chk("s3_wt_busy",     ROW_W'(bus.s_ready),   '0);
    @(posedge clock); #1;
    chk("s3_wt_ready",    ROW_W'(bus.s_ready),   ROW_W'(1));
    send_rows(DR + 1, NB * WR - 1, 1'b0, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    chk("s3_done_cnt", ROW_W'(done_cnt),     ROW_W'(1));
    chk("s3_phase",    ROW_W'(bus.phase),    '0);
    chk("s3_sync_err", ROW_W'(bus.sync_err), '0);
    check_rows("s3");

    // 4. stray s_last on byte 7 of data row 3
    send_rows(0, 3, 1'b0, 1'b0);
    chk("s4_err_before", ROW_W'(bus.sync_err), '0);
    for (int j = 0; j < 7; j++) send_byte(8'($urandom), j == 6, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    chk("s4_err_after", ROW_W'(bus.sync_err), ROW_W'(1));
    send_rows(0, 1, 1'b0, 1'b0);
    check_rows("s4");

    // 5. random s_valid gaps over a full frame
    do_reset();
    send_rows(0, FRAME_ROWS, 1'b1, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    chk("s5_done_cnt", ROW_W'(done_cnt),     ROW_W'(1));
    chk("s5_phase",    ROW_W'(bus.phase),    '0);
    chk("s5_sync_err", ROW_W'(bus.sync_err), '0);
    check_rows("s5");

    // 5b. frame without s_last still completes, flags sync_err
    done_cnt = 0;
    send_rows(0, FRAME_ROWS, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("s5b_done_cnt", ROW_W'(done_cnt),     ROW_W'(1));
    chk("s5b_sync_err", ROW_W'(bus.sync_err), ROW_W'(1));
    chk("s5b_phase",    ROW_W'(bus.phase),    '0);
    check_rows("s5b");

    // 6. reset during the hold of weight row 17, block 4
    do_reset();
    send_rows(0, DR + 4 * WR + 18, 1'b0, 1'b0);
    chk("s6_pre_valid", ROW_W'(bus.row_valid), ROW_W'(1));
    chk("s6_pre_count", ROW_W'(bus.count),     ROW_W'(17));
    chk("s6_pre_phase", ROW_W'(bus.phase),     ROW_W'(1));
    reset = 1'b0;
    #1;
    chk("s6_row_data",  bus.row_data,          '0);
    chk("s6_count",     ROW_W'(bus.count),     '0);
    chk("s6_row_valid", ROW_W'(bus.row_valid), '0);
    chk("s6_phase",     ROW_W'(bus.phase),     '0);
    chk("s6_ready",     ROW_W'(bus.s_ready),   '0);
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    send_rows(0, 1, 1'b0, 1'b0);
    check_rows("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
